// File: rtl/rv32i_decoder_stage_pkg.sv
// Shared RV32I decode constants: one-hot widths and bit indices, opcodes, decode payload.
package rv32i_decoder_stage_pkg;

    localparam int unsigned ALU_WIDTH       = 14;
    localparam int unsigned OPCODE_WIDTH    = 11;
    localparam int unsigned EXCEPTION_WIDTH = 4;

    // ALU one-hot bit indices
    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_SLT  = 2;
    localparam int unsigned ALU_SLTU = 3;
    localparam int unsigned ALU_XOR  = 4;
    localparam int unsigned ALU_OR   = 5;
    localparam int unsigned ALU_AND  = 6;
    localparam int unsigned ALU_SLL  = 7;
    localparam int unsigned ALU_SRL  = 8;
    localparam int unsigned ALU_SRA  = 9;
    localparam int unsigned ALU_EQ   = 10;
    localparam int unsigned ALU_NEQ  = 11;
    localparam int unsigned ALU_GE   = 12;
    localparam int unsigned ALU_GEU  = 13;

    // Opcode-class one-hot bit indices
    localparam int unsigned OP_RTYPE  = 0;
    localparam int unsigned OP_ITYPE  = 1;
    localparam int unsigned OP_LOAD   = 2;
    localparam int unsigned OP_STORE  = 3;
    localparam int unsigned OP_BRANCH = 4;
    localparam int unsigned OP_JAL    = 5;
    localparam int unsigned OP_JALR   = 6;
    localparam int unsigned OP_LUI    = 7;
    localparam int unsigned OP_AUIPC  = 8;
    localparam int unsigned OP_SYSTEM = 9;
    localparam int unsigned OP_FENCE  = 10;

    // Exception one-hot bit indices
    localparam int unsigned EXC_ILLEGAL = 0;
    localparam int unsigned EXC_ECALL   = 1;
    localparam int unsigned EXC_EBREAK  = 2;
    localparam int unsigned EXC_MRET    = 3;

    // RV32I major opcodes
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0]                imm;
        logic [ALU_WIDTH-1:0]       alu;
        logic [OPCODE_WIDTH-1:0]    opcode;
        logic [EXCEPTION_WIDTH-1:0] exception;
    } decode_t;

    // ALU op for register/immediate arithmetic; alt is instr[30]
    function automatic logic [ALU_WIDTH-1:0] alu_by_funct3(input logic [2:0] funct3,
                                                           input logic alt,
                                                           input logic is_rtype);
        logic [ALU_WIDTH-1:0] r;
        r = '0;
        case (funct3)
            3'b000:  r[(is_rtype && alt) ? ALU_SUB : ALU_ADD] = 1'b1;
            3'b001:  r[ALU_SLL]  = 1'b1;
            3'b010:  r[ALU_SLT]  = 1'b1;
            3'b011:  r[ALU_SLTU] = 1'b1;
            3'b100:  r[ALU_XOR]  = 1'b1;
            3'b101:  r[alt ? ALU_SRA : ALU_SRL] = 1'b1;
            3'b110:  r[ALU_OR]   = 1'b1;
            default: r[ALU_AND]  = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv32i_decoder_stage_reg_file.sv
// Register file: DEPTH x DWIDTH, two combinational read ports, one clocked write, x0 hardwired to 0.
module rv32i_decoder_stage_reg_file #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned DEPTH  = 1 << AWIDTH
) (
    input  logic              ds_clk,
    input  logic              ds_rst,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr1,
    input  logic [AWIDTH-1:0] raddr2,
    output logic [DWIDTH-1:0] rdata1,
    output logic [DWIDTH-1:0] rdata2
);

    logic [DWIDTH-1:0] mem [DEPTH];

    // Clear on reset; write-back ignores x0
    always_ff @(posedge ds_clk or negedge ds_rst) begin
        if (!ds_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports see the pre-edge contents, so a same-cycle write returns the old value
    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/rv32i_decoder_stage.sv
// RV32I decode stage: registered decode of one instruction per enabled cycle plus register file.
module rv32i_decoder_stage
    import rv32i_decoder_stage_pkg::*;
#(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned AWIDTH   = 5,
    parameter int unsigned DEPTH    = 1 << AWIDTH,
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned IWIDTH   = 32
) (
    input  logic                       ds_clk,
    input  logic                       ds_rst,
    input  logic [IWIDTH-1:0]          ds_i_instr,
    input  logic [PC_WIDTH-1:0]        ds_i_pc,
    output logic [PC_WIDTH-1:0]        ds_o_pc,
    output logic [AWIDTH-1:0]          ds_o_addr_rs1_p,
    output logic [AWIDTH-1:0]          ds_o_addr_rs2_p,
    output logic [AWIDTH-1:0]          ds_o_addr_rd_p,
    output logic [2:0]                 ds_o_funct3,
    output logic [DWIDTH-1:0]          ds_o_imm,
    output logic [ALU_WIDTH-1:0]       ds_o_alu,
    output logic [OPCODE_WIDTH-1:0]    ds_o_opcode,
    output logic [EXCEPTION_WIDTH-1:0] ds_o_exception,
    input  logic                       ds_i_ce,
    output logic                       ds_o_ce,
    input  logic                       ds_i_stall,
    output logic                       ds_o_stall,
    input  logic                       ds_i_flush,
    output logic                       ds_o_flush,
    input  logic [DWIDTH-1:0]          ds_data_in_rd,
    input  logic                       ds_we,
    output logic [DWIDTH-1:0]          ds_data_out_rs1,
    output logic [DWIDTH-1:0]          ds_data_out_rs2
);

    decode_t    dec;
    logic [6:0] opc;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       advance;

    assign opc     = ds_i_instr[6:0];
    assign funct3  = ds_i_instr[14:12];
    assign funct7  = ds_i_instr[31:25];
    assign advance = ds_i_ce && !ds_i_stall;

    // Decode the incoming instruction into immediate, ALU op, class and exception
    always_comb begin
        dec = '0;
        case (opc)
            OPC_RTYPE: begin
                dec.opcode[OP_RTYPE] = 1'b1;
                dec.alu = alu_by_funct3(funct3, ds_i_instr[30], 1'b1);
                dec.exception[EXC_ILLEGAL] = !((funct7 == FUNCT7_BASE) ||
                    ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OPC_ITYPE: begin
                dec.opcode[OP_ITYPE] = 1'b1;
                dec.imm = {{20{ds_i_instr[31]}}, ds_i_instr[31:20]};
                dec.alu = alu_by_funct3(funct3, ds_i_instr[30], 1'b0);
                dec.exception[EXC_ILLEGAL] = ((funct3 == 3'b001) && (funct7 != FUNCT7_BASE)) ||
                    ((funct3 == 3'b101) && (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT));
            end
            OPC_LOAD: begin
                dec.opcode[OP_LOAD] = 1'b1;
                dec.imm = {{20{ds_i_instr[31]}}, ds_i_instr[31:20]};
                dec.alu[ALU_ADD] = 1'b1;
            end
            OPC_STORE: begin
                dec.opcode[OP_STORE] = 1'b1;
                dec.imm = {{20{ds_i_instr[31]}}, ds_i_instr[31:25], ds_i_instr[11:7]};
                dec.alu[ALU_ADD] = 1'b1;
            end
            OPC_BRANCH: begin
                dec.opcode[OP_BRANCH] = 1'b1;
                dec.imm = {{19{ds_i_instr[31]}}, ds_i_instr[31], ds_i_instr[7],
                           ds_i_instr[30:25], ds_i_instr[11:8], 1'b0};
                case (funct3)
                    3'b000:  dec.alu[ALU_EQ]   = 1'b1;
                    3'b001:  dec.alu[ALU_NEQ]  = 1'b1;
                    3'b100:  dec.alu[ALU_SLT]  = 1'b1;
                    3'b101:  dec.alu[ALU_GE]   = 1'b1;
                    3'b110:  dec.alu[ALU_SLTU] = 1'b1;
                    3'b111:  dec.alu[ALU_GEU]  = 1'b1;
                    default: dec.alu = '0;
                endcase
            end
            OPC_JAL: begin
                dec.opcode[OP_JAL] = 1'b1;
                dec.imm = {{11{ds_i_instr[31]}}, ds_i_instr[31], ds_i_instr[19:12],
                           ds_i_instr[20], ds_i_instr[30:21], 1'b0};
                dec.alu[ALU_ADD] = 1'b1;
            end
            OPC_JALR: begin
                dec.opcode[OP_JALR] = 1'b1;
                dec.imm = {{20{ds_i_instr[31]}}, ds_i_instr[31:20]};
                dec.alu[ALU_ADD] = 1'b1;
            end
            OPC_LUI: begin
                dec.opcode[OP_LUI] = 1'b1;
                dec.imm = {ds_i_instr[31:12], 12'b0};
                dec.alu[ALU_ADD] = 1'b1;
            end
            OPC_AUIPC: begin
                dec.opcode[OP_AUIPC] = 1'b1;
                dec.imm = {ds_i_instr[31:12], 12'b0};
                dec.alu[ALU_ADD] = 1'b1;
            end
            OPC_SYSTEM: begin
                dec.opcode[OP_SYSTEM] = 1'b1;
                dec.imm = {{20{ds_i_instr[31]}}, ds_i_instr[31:20]};
                if (funct3 == 3'b000) begin
                    case (ds_i_instr[31:20])
                        12'h000: dec.exception[EXC_ECALL]  = 1'b1;
                        12'h001: dec.exception[EXC_EBREAK] = 1'b1;
                        12'h302: dec.exception[EXC_MRET]   = 1'b1;
                        default: dec.exception = '0;
                    endcase
                end
            end
            OPC_FENCE: begin
                dec.opcode[OP_FENCE] = 1'b1;
                dec.imm = {{20{ds_i_instr[31]}}, ds_i_instr[31:20]};
            end
            default: dec.exception[EXC_ILLEGAL] = 1'b1;
        endcase
    end

    // Pipeline register: flush kills valid, stall holds everything, ce+!stall loads decode
    always_ff @(posedge ds_clk or negedge ds_rst) begin
        if (!ds_rst) begin
            ds_o_ce         <= 1'b0;
            ds_o_pc         <= '0;
            ds_o_addr_rs1_p <= '0;
            ds_o_addr_rs2_p <= '0;
            ds_o_addr_rd_p  <= '0;
            ds_o_funct3     <= '0;
            ds_o_imm        <= '0;
            ds_o_alu        <= '0;
            ds_o_opcode     <= '0;
            ds_o_exception  <= '0;
        end else begin
            if (ds_i_flush) begin
                ds_o_ce <= 1'b0;
            end else if (!ds_i_stall) begin
                ds_o_ce <= ds_i_ce;
            end
            if (advance) begin
                ds_o_pc         <= ds_i_pc;
                ds_o_addr_rs1_p <= ds_i_instr[19:15];
                ds_o_addr_rs2_p <= ds_i_instr[24:20];
                ds_o_addr_rd_p  <= ds_i_instr[11:7];
                ds_o_funct3     <= funct3;
                ds_o_imm        <= DWIDTH'(dec.imm);
                ds_o_alu        <= dec.alu;
                ds_o_opcode     <= dec.opcode;
                ds_o_exception  <= dec.exception;
            end
        end
    end

    // Handshake pass-through to neighbouring stages
    assign ds_o_stall = ds_i_stall;
    assign ds_o_flush = ds_i_flush;

    rv32i_decoder_stage_reg_file #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH),
        .DEPTH  (DEPTH)
    ) u_reg_file (
        .ds_clk (ds_clk),
        .ds_rst (ds_rst),
        .we     (ds_we),
        .waddr  (ds_o_addr_rd_p),
        .wdata  (ds_data_in_rd),
        .raddr1 (ds_o_addr_rs1_p),
        .raddr2 (ds_o_addr_rs2_p),
        .rdata1 (ds_data_out_rs1),
        .rdata2 (ds_data_out_rs2)
    );

endmodule

// File: tb/tb_rv32i_decoder_stage.sv
// Bench for rv32i_decoder_stage: directed literal checks, then random traffic against a table-driven model.
module tb_rv32i_decoder_stage;

    logic        ds_clk;
    logic        ds_rst;
    logic [31:0] ds_i_instr;
    logic [31:0] ds_i_pc;
    logic [31:0] ds_o_pc;
    logic [4:0]  ds_o_addr_rs1_p;
    logic [4:0]  ds_o_addr_rs2_p;
    logic [4:0]  ds_o_addr_rd_p;
    logic [2:0]  ds_o_funct3;
    logic [31:0] ds_o_imm;
    logic [13:0] ds_o_alu;
    logic [10:0] ds_o_opcode;
    logic [3:0]  ds_o_exception;
    logic        ds_i_ce;
    logic        ds_o_ce;
    logic        ds_i_stall;
    logic        ds_o_stall;
    logic        ds_i_flush;
    logic        ds_o_flush;
    logic [31:0] ds_data_in_rd;
    logic        ds_we;
    logic [31:0] ds_data_out_rs1;
    logic [31:0] ds_data_out_rs2;

    rv32i_decoder_stage dut (
        .ds_clk          (ds_clk),
        .ds_rst          (ds_rst),
        .ds_i_instr      (ds_i_instr),
        .ds_i_pc         (ds_i_pc),
        .ds_o_pc         (ds_o_pc),
        .ds_o_addr_rs1_p (ds_o_addr_rs1_p),
        .ds_o_addr_rs2_p (ds_o_addr_rs2_p),
        .ds_o_addr_rd_p  (ds_o_addr_rd_p),
        .ds_o_funct3     (ds_o_funct3),
        .ds_o_imm        (ds_o_imm),
        .ds_o_alu        (ds_o_alu),
        .ds_o_opcode     (ds_o_opcode),
        .ds_o_exception  (ds_o_exception),
        .ds_i_ce         (ds_i_ce),
        .ds_o_ce         (ds_o_ce),
        .ds_i_stall      (ds_i_stall),
        .ds_o_stall      (ds_o_stall),
        .ds_i_flush      (ds_i_flush),
        .ds_o_flush      (ds_o_flush),
        .ds_data_in_rd   (ds_data_in_rd),
        .ds_we           (ds_we),
        .ds_data_out_rs1 (ds_data_out_rs1),
        .ds_data_out_rs2 (ds_data_out_rs2)
    );

    initial ds_clk = 1'b0;
    always #5 ds_clk = ~ds_clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [13:0] alu;
        logic [10:0] opc;
        logic [3:0]  exc;
        logic        ce;
    } model_t;

    // Class order matches the one-hot opcode bit order; alu indices follow ADD..GEU
    logic [6:0]  opc_tab [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};
    int          alu_f3  [8]  = '{0, 7, 2, 3, 4, 8, 5, 6};
    int          br_f3   [8]  = '{10, 11, -1, -1, 2, 12, 3, 13};
    logic [31:0] sys_tab [3]  = '{32'h00000073, 32'h00100073, 32'h30200073};

    model_t      cur;
    logic [31:0] rf [32];
    int          total = 0;
    int          bad   = 0;
    logic        chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected decode straight from the field layout rules
    function automatic model_t decode_model(input logic [31:0] ins, input logic [31:0] pc);
        model_t             m;
        int                 k;
        int                 a;
        int                 f3;
        int                 f7;
        logic signed [31:0] s;
        logic [31:0]        imm_i, imm_s, imm_b, imm_u, imm_j;
        m     = '0;
        m.pc  = pc;
        m.rs1 = ins[19:15];
        m.rs2 = ins[24:20];
        m.rd  = ins[11:7];
        m.f3  = ins[14:12];
        f3    = int'(ins[14:12]);
        f7    = int'(ins[31:25]);
        s     = ins;
        imm_i = 32'(s >>> 20);
        imm_s = (32'(s >>> 25) << 5) | 32'(ins[11:7]);
        imm_b = (32'(s >>> 31) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        imm_u = ins & 32'hFFFFF000;
        imm_j = (32'(s >>> 31) << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        k = -1;
        for (int j = 0; j < 11; j++) if (ins[6:0] == opc_tab[j]) k = j;
        a = -1;
        case (k)
            0: begin
                a = alu_f3[f3];
                if (ins[30] && f3 == 0) a = 1;
                if (ins[30] && f3 == 5) a = 9;
                m.exc[0] = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
            end
            1: begin
                m.imm = imm_i;
                a = alu_f3[f3];
                if (ins[30] && f3 == 5) a = 9;
                m.exc[0] = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
            end
            2, 6:  begin m.imm = imm_i; a = 0; end
            3:     begin m.imm = imm_s; a = 0; end
            4:     begin m.imm = imm_b; a = br_f3[f3]; end
            5:     begin m.imm = imm_j; a = 0; end
            7, 8:  begin m.imm = imm_u; a = 0; end
            9: begin
                m.imm = imm_i;
                if (f3 == 0 && ins[31:20] == 12'h000) m.exc = 4'b0010;
                if (f3 == 0 && ins[31:20] == 12'h001) m.exc = 4'b0100;
                if (f3 == 0 && ins[31:20] == 12'h302) m.exc = 4'b1000;
            end
            10:      m.imm = imm_i;
            default: m.exc = 4'b0001;
        endcase
        if (a >= 0) m.alu = 14'(1 << a);
        if (k >= 0) m.opc = 11'(1 << k);
        return m;
    endfunction

    // Drive one cycle of inputs, advance the model across the next rising edge
    task automatic do_cycle(input logic [31:0] instr, input logic [31:0] pc, input logic ce,
                            input logic stall, input logic flush, input logic we, input logic [31:0] wd);
        model_t     nxt;
        logic       wr;
        logic [4:0] wa;
        ds_i_instr    = instr;
        ds_i_pc       = pc;
        ds_i_ce       = ce;
        ds_i_stall    = stall;
        ds_i_flush    = flush;
        ds_we         = we;
        ds_data_in_rd = wd;
        nxt = cur;
        if (flush) nxt.ce = 1'b0;
        else if (!stall) nxt.ce = ce;
        if (ce && !stall) begin
            logic c;
            c = nxt.ce;
            nxt = decode_model(instr, pc);
            nxt.ce = c;
        end
        wa = cur.rd;
        wr = we && (wa != 5'd0);
        if (!ds_rst) begin
            nxt = '0;
            wr  = 1'b0;
        end
        @(posedge ds_clk);
        #2;
        cur = nxt;
        if (wr) rf[wa] = wd;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 12);
        if (k == 11) return sys_tab[$urandom_range(0, 2)];
        if (k == 12) return r;
        r[6:0] = opc_tab[k];
        if ((k == 0 || k == 1) && $urandom_range(0, 3) != 0)
            r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return r;
    endfunction

    // Per-cycle comparison of every output against the model
    always @(negedge ds_clk) begin
        if (chk_en) begin
            check("pc",      ds_o_pc,                cur.pc);
            check("rs1",     32'(ds_o_addr_rs1_p),   32'(cur.rs1));
            check("rs2",     32'(ds_o_addr_rs2_p),   32'(cur.rs2));
            check("rd",      32'(ds_o_addr_rd_p),    32'(cur.rd));
            check("funct3",  32'(ds_o_funct3),       32'(cur.f3));
            check("imm",     ds_o_imm,               cur.imm);
            check("alu",     32'(ds_o_alu),          32'(cur.alu));
            check("opcode",  32'(ds_o_opcode),       32'(cur.opc));
            check("exc",     32'(ds_o_exception),    32'(cur.exc));
            check("ce",      32'(ds_o_ce),           32'(cur.ce));
            check("stall",   32'(ds_o_stall),        32'(ds_i_stall));
            check("flush",   32'(ds_o_flush),        32'(ds_i_flush));
            check("rs1data", ds_data_out_rs1,        rf[cur.rs1]);
            check("rs2data", ds_data_out_rs2,        rf[cur.rs2]);
        end
    end

    initial begin
        ds_rst        = 1'b0;
        ds_i_instr    = '0;
        ds_i_pc       = '0;
        ds_i_ce       = 1'b0;
        ds_i_stall    = 1'b0;
        ds_i_flush    = 1'b0;
        ds_we         = 1'b0;
        ds_data_in_rd = '0;
        cur           = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        #1 chk_en = 1'b1;
        #1;
        check("rst_ce",  32'(ds_o_ce), 32'd0);
        check("rst_pc",  ds_o_pc,      32'd0);
        check("rst_imm", ds_o_imm,     32'd0);
        repeat (2) @(posedge ds_clk);
        #2 ds_rst = 1'b1;

        do_cycle(32'h003100B3, 32'h100, 1, 0, 0, 0, 0);
        check("add_rd",  32'(ds_o_addr_rd_p),  32'd1);
        check("add_rs1", 32'(ds_o_addr_rs1_p), 32'd2);
        check("add_rs2", 32'(ds_o_addr_rs2_p), 32'd3);
        check("add_opc", 32'(ds_o_opcode),     32'h1);
        check("add_alu", 32'(ds_o_alu),        32'h1);
        check("add_imm", ds_o_imm,             32'd0);
        check("add_ce",  32'(ds_o_ce),         32'd1);
        check("add_exc", 32'(ds_o_exception),  32'd0);
        check("add_pc",  ds_o_pc,              32'h100);

        do_cycle(32'hFFF00293, 32'h104, 1, 0, 0, 0, 0);
        check("addi_opc", 32'(ds_o_opcode), 32'h2);
        check("addi_alu", 32'(ds_o_alu),    32'h1);
        check("addi_imm", ds_o_imm,         32'hFFFFFFFF);

        // rd_p is 5 during this cycle, so DEADBEEF lands in x5 and shows on rs2 (=5) right away
        do_cycle(32'h00532423, 32'h108, 1, 0, 0, 1, 32'hDEADBEEF);
        check("sw_opc",   32'(ds_o_opcode),     32'h8);
        check("sw_rs1",   32'(ds_o_addr_rs1_p), 32'd6);
        check("sw_rs2",   32'(ds_o_addr_rs2_p), 32'd5);
        check("sw_imm",   ds_o_imm,             32'd8);
        check("x5_rs2",   ds_data_out_rs2,      32'hDEADBEEF);

        do_cycle(32'h0002A003, 32'h10C, 1, 0, 0, 0, 0);
        check("x5_rs1",   ds_data_out_rs1,      32'hDEADBEEF);

        // rd_p is 0 here: the write must be dropped
        do_cycle(32'h00208863, 32'h110, 1, 0, 0, 1, 32'h12345678);
        check("beq_opc",  32'(ds_o_opcode), 32'h10);
        check("beq_alu",  32'(ds_o_alu),    32'h400);
        check("beq_imm",  ds_o_imm,         32'd16);

        do_cycle(32'h00002003, 32'h114, 1, 0, 0, 0, 0);
        check("x0_read",  ds_data_out_rs1,  32'd0);

        do_cycle(32'h123451B7, 32'h118, 1, 0, 0, 0, 0);
        check("lui_opc",  32'(ds_o_opcode), 32'h80);
        check("lui_imm",  ds_o_imm,         32'h12345000);
        do_cycle(32'h014000EF, 32'h11C, 1, 0, 0, 0, 0);
        check("jal_opc",  32'(ds_o_opcode), 32'h20);
        check("jal_imm",  ds_o_imm,         32'd20);
        do_cycle(32'h00000073, 32'h120, 1, 0, 0, 0, 0);
        check("ecall",    32'(ds_o_exception), 32'h2);
        do_cycle(32'h00100073, 32'h124, 1, 0, 0, 0, 0);
        check("ebreak",   32'(ds_o_exception), 32'h4);
        do_cycle(32'h30200073, 32'h128, 1, 0, 0, 0, 0);
        check("mret",     32'(ds_o_exception), 32'h8);
        do_cycle(32'h0000007F, 32'h12C, 1, 0, 0, 0, 0);
        check("illegal",  32'(ds_o_exception), 32'h1);
        check("ill_opc",  32'(ds_o_opcode),    32'h0);

        do_cycle(32'h003100B3, 32'h200, 1, 1, 0, 0, 0);
        check("stall_pc",  ds_o_pc,              32'h12C);
        check("stall_exc", 32'(ds_o_exception),  32'h1);
        check("stall_ce",  32'(ds_o_ce),         32'd1);
        check("stall_out", 32'(ds_o_stall),      32'd1);

        do_cycle(32'h003100B3, 32'h204, 1, 0, 1, 0, 0);
        check("flush_ce",  32'(ds_o_ce),    32'd0);
        check("flush_out", 32'(ds_o_flush), 32'd1);
        check("flush_pc",  ds_o_pc,         32'h204);

        // Async reset between edges clears outputs and registers immediately
        do_cycle(32'h0002A003, 32'h208, 1, 0, 0, 0, 0);
        check("pre_rst",  ds_data_out_rs1, 32'hDEADBEEF);
        #1;
        ds_rst = 1'b0;
        cur    = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        #1;
        check("arst_pc",   ds_o_pc,              32'd0);
        check("arst_ce",   32'(ds_o_ce),         32'd0);
        check("arst_rs1",  32'(ds_o_addr_rs1_p), 32'd0);
        check("arst_data", ds_data_out_rs1,      32'd0);
        do_cycle(32'h003100B3, 32'h300, 1, 0, 0, 1, 32'h55AA55AA);
        ds_rst = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            do_cycle(gen_instr(), $urandom, ($urandom_range(0, 4) != 0),
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 1) != 0), $urandom);
        end

        @(negedge ds_clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
